// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the transaction FSM state type for axi_cache_master.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5,
        ST_RSP  = 3'd6
    } state_e;

endpackage

// File: rtl/axi_cache_master.sv
// Single-outstanding AXI4 master that turns cache line / uncached word requests into
// AR/R or AW/W/B transactions. Every output is driven straight from a flop.
module axi_cache_master
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0,
    parameter int LINE_WORDS = 4,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic                             req_uncached,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0]            req_wstrb,

    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] rsp_rdata,
    output logic                             rsp_error,

    output logic [ID_WIDTH-1:0]              m_axi_awid,
    output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
    output logic [7:0]                       m_axi_awlen,
    output logic [2:0]                       m_axi_awsize,
    output logic [1:0]                       m_axi_awburst,
    output logic                             m_axi_awlock,
    output logic [3:0]                       m_axi_awcache,
    output logic [2:0]                       m_axi_awprot,
    output logic                             m_axi_awvalid,
    input  logic                             m_axi_awready,

    output logic [DATA_WIDTH-1:0]            m_axi_wdata,
    output logic [STRB_WIDTH-1:0]            m_axi_wstrb,
    output logic                             m_axi_wlast,
    output logic                             m_axi_wvalid,
    input  logic                             m_axi_wready,

    input  logic [ID_WIDTH-1:0]              m_axi_bid,
    input  logic [1:0]                       m_axi_bresp,
    input  logic                             m_axi_bvalid,
    output logic                             m_axi_bready,

    output logic [ID_WIDTH-1:0]              m_axi_arid,
    output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
    output logic [7:0]                       m_axi_arlen,
    output logic [2:0]                       m_axi_arsize,
    output logic [1:0]                       m_axi_arburst,
    output logic                             m_axi_arlock,
    output logic [3:0]                       m_axi_arcache,
    output logic [2:0]                       m_axi_arprot,
    output logic                             m_axi_arvalid,
    input  logic                             m_axi_arready,

    input  logic [ID_WIDTH-1:0]              m_axi_rid,
    input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
    input  logic [1:0]                       m_axi_rresp,
    input  logic                             m_axi_rlast,
    input  logic                             m_axi_rvalid,
    output logic                             m_axi_rready,

    output logic [2:0]                       dbg_state
);

    localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH;
    localparam int BW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int OFF_WORD  = $clog2(STRB_WIDTH);
    localparam int OFF_LINE  = $clog2(LINE_WORDS * STRB_WIDTH);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {ADDR_WIDTH{1'b1}} << OFF_WORD;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF_LINE;
    localparam logic [BW-1:0]         LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [7:0]            LINE_LEN  = 8'(LINE_WORDS - 1);

    // Handshake rule on every channel: a beat transfers on the rising edge where
    // valid and ready are both high; valid never drops and payload never changes
    // before that edge.

    state_e                  state_q;
    logic                    req_ready_q;
    logic                    uncached_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic [LINE_BITS-1:0]    line_q;
    logic [BW-1:0]           beat_q;
    logic                    err_q;
    logic                    arvalid_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    wlast_q;
    logic                    rready_q;
    logic                    bready_q;
    logic                    rsp_valid_q;

    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [7:0]              len_d;
    logic [STRB_WIDTH-1:0]   wstrb_d;

    always_comb begin
        addr_d  = req_addr & (req_uncached ? WORD_MASK : LINE_MASK);
        len_d   = req_uncached ? 8'd0 : LINE_LEN;
        wstrb_d = req_uncached ? req_wstrb : {STRB_WIDTH{1'b1}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            uncached_q  <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            wstrb_q     <= '0;
            line_q      <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        uncached_q  <= req_uncached;
                        addr_q      <= addr_d;
                        len_q       <= len_d;
                        wstrb_q     <= wstrb_d;
                        beat_q      <= '0;
                        err_q       <= 1'b0;
                        // Reads start from a zeroed line so unused words of an uncached read stay 0.
                        line_q      <= req_write ? req_wdata : '0;
                        if (req_write) begin
                            awvalid_q <= 1'b1;
                            state_q   <= ST_AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (m_axi_rvalid) begin
                        line_q[beat_q*DATA_WIDTH +: DATA_WIDTH] <= m_axi_rdata;
                        if (beat_q != LAST_BEAT) beat_q <= beat_q + 1'b1;
                        if (m_axi_rresp[1]) err_q <= 1'b1;
                        if (m_axi_rlast) begin
                            rready_q    <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RSP;
                        end
                    end
                end
                ST_AW: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= (len_q == 8'd0);
                        state_q   <= ST_W;
                    end
                end
                ST_W: begin
                    if (m_axi_wready) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= ST_B;
                        end else begin
                            // The outgoing word is always the low slice; shift the next one down.
                            line_q  <= line_q >> DATA_WIDTH;
                            beat_q  <= beat_q + 1'b1;
                            wlast_q <= ((8'(beat_q) + 8'd1) == len_q);
                        end
                    end
                end
                ST_B: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp[1]) err_q <= 1'b1;
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = line_q;
    assign rsp_error     = err_q;

    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = 3'(OFF_WORD);
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = uncached_q ? 4'b0000 : 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;

    assign m_axi_wdata   = line_q[DATA_WIDTH-1:0];
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = 3'(OFF_WORD);
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = uncached_q ? 4'b0000 : 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

    assign dbg_state     = state_q;

    // IDs and the exclusive-okay bit carry no meaning with one transaction in flight.
    logic unused_ok;
    assign unused_ok = ^{m_axi_bid, m_axi_rid, m_axi_bresp[0], m_axi_rresp[0]};

endmodule
